// File: rtl/down_counter.sv
// down_counter: enable-gated binary down counter with terminal-count carry-out, plus 3/4-bit wrappers
module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt,
  output logic             co,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] r_count;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_count <= '1;
    else if (cnt) r_count <= r_count - WIDTH'(1);
  always_comb co = cnt && (r_count == '0);
  assign count = r_count;
endmodule

module down_counter_3bit (
  input  logic       cnt,
  input  logic       clk,
  input  logic       rst,
  output logic       co,
  output logic [2:0] count
);
  down_counter #(.WIDTH(3)) u_core (.clk(clk), .rst(rst), .cnt(cnt), .co(co), .count(count));
endmodule

module down_counter_4bit (
  input  logic       cnt,
  input  logic       clk,
  input  logic       rst,
  output logic       co,
  output logic [3:0] count
);
  down_counter #(.WIDTH(4)) u_core (.clk(clk), .rst(rst), .cnt(cnt), .co(co), .count(count));
endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter: directed scoreboard bench for a 3-bit and a 4-bit down_counter, chainable
module tb_down_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cnt3 = 1'b0;
  logic cnt4 = 1'b0;
  logic chain = 1'b0;
  logic co3, co4, w_cnt4;
  logic [2:0] count3;
  logic [3:0] count4;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    string      nm;
    logic [2:0] e3;
    logic       ec3;
    logic [3:0] e4;
    logic       ec4;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  assign w_cnt4 = chain ? co3 : cnt4;

  down_counter #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .cnt(cnt3), .co(co3), .count(count3));
  down_counter #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .cnt(w_cnt4), .co(co4), .count(count4));

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs change 1ns after an edge; the expected state is observed on the following falling edge.
  task automatic step(input logic r, input logic a, input logic b, input logic ch, input string nm,
                      input logic [2:0] e3, input logic ec3, input logic [3:0] e4, input logic ec4);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; cnt3 = a; cnt4 = b; chain = ch;
    e.nm = nm; e.e3 = e3; e.ec3 = ec3; e.e4 = e4; e.ec4 = ec4;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        check({e.nm, ".count3"}, {1'b0, count3}, {1'b0, e.e3});
        check({e.nm, ".co3"}, {3'b0, co3}, {3'b0, e.ec3});
        check({e.nm, ".count4"}, count4, e.e4);
        check({e.nm, ".co4"}, {3'b0, co4}, {3'b0, e.ec4});
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    #2 rst = 1'b1; cnt3 = 1'b1; cnt4 = 1'b1;
    step(1, 1, 1, 0, "reset0", 7, 0, 15, 0);
    step(1, 1, 1, 0, "reset1", 7, 0, 15, 0);
    step(0, 0, 0, 0, "release", 7, 0, 15, 0);
    step(0, 0, 0, 0, "hold0", 7, 0, 15, 0);
    step(0, 0, 0, 0, "hold1", 7, 0, 15, 0);
    step(0, 1, 1, 0, "alt0", 7, 0, 15, 0);
    step(0, 0, 0, 0, "alt1", 6, 0, 14, 0);
    step(0, 1, 1, 0, "alt2", 6, 0, 14, 0);
    step(0, 0, 0, 0, "alt3", 5, 0, 13, 0);
    step(0, 1, 1, 0, "alt4", 5, 0, 13, 0);
    step(0, 0, 0, 0, "alt5", 4, 0, 12, 0);
    step(0, 1, 1, 0, "alt6", 4, 0, 12, 0);
    step(0, 0, 0, 0, "alt7", 3, 0, 11, 0);
    step(0, 1, 1, 0, "alt8", 3, 0, 11, 0);
    step(0, 0, 0, 0, "alt9", 2, 0, 10, 0);
    step(1, 0, 0, 0, "async_rst", 7, 0, 15, 0);
    step(0, 1, 1, 0, "wrap_start", 7, 0, 15, 0);
    step(0, 1, 1, 0, "wrap1", 6, 0, 14, 0);
    step(0, 1, 1, 0, "wrap2", 5, 0, 13, 0);
    step(0, 1, 1, 0, "wrap3", 4, 0, 12, 0);
    step(0, 1, 1, 0, "wrap4", 3, 0, 11, 0);
    step(0, 1, 1, 0, "wrap5", 2, 0, 10, 0);
    step(0, 1, 1, 0, "wrap6", 1, 0, 9, 0);
    step(0, 1, 1, 0, "wrap7_tc3", 0, 1, 8, 0);
    step(0, 1, 1, 0, "wrap8_wrap3", 7, 0, 7, 0);
    step(0, 1, 1, 0, "wrap9", 6, 0, 6, 0);
    step(0, 1, 1, 0, "wrap10", 5, 0, 5, 0);
    step(0, 1, 1, 0, "wrap11", 4, 0, 4, 0);
    step(0, 1, 1, 0, "wrap12", 3, 0, 3, 0);
    step(0, 1, 1, 0, "wrap13", 2, 0, 2, 0);
    step(0, 1, 1, 0, "wrap14", 1, 0, 1, 0);
    step(0, 1, 0, 0, "wrap15_cnt4_low", 0, 1, 0, 0);
    step(0, 1, 1, 0, "tc4_hold", 7, 0, 0, 1);
    step(0, 1, 1, 0, "wrap4_to_15", 6, 0, 15, 0);
    step(1, 1, 1, 0, "chain_rst", 7, 0, 15, 0);
    step(0, 1, 0, 1, "chain0", 7, 0, 15, 0);
    step(0, 1, 0, 1, "chain1", 6, 0, 15, 0);
    step(0, 1, 0, 1, "chain2", 5, 0, 15, 0);
    step(0, 1, 0, 1, "chain3", 4, 0, 15, 0);
    step(0, 1, 0, 1, "chain4", 3, 0, 15, 0);
    step(0, 1, 0, 1, "chain5", 2, 0, 15, 0);
    step(0, 1, 0, 1, "chain6", 1, 0, 15, 0);
    step(0, 1, 0, 1, "chain7_tc3", 0, 1, 15, 0);
    step(0, 1, 0, 1, "chain8", 7, 0, 14, 0);
    step(0, 1, 0, 1, "chain9", 6, 0, 14, 0);
    step(0, 1, 0, 1, "chain10", 5, 0, 14, 0);
    step(0, 1, 0, 1, "chain11", 4, 0, 14, 0);
    step(0, 1, 0, 1, "chain12", 3, 0, 14, 0);
    step(0, 1, 0, 1, "chain13", 2, 0, 14, 0);
    step(0, 1, 0, 1, "chain14", 1, 0, 14, 0);
    step(0, 1, 0, 1, "chain15_tc3", 0, 1, 14, 0);
    step(0, 1, 0, 1, "chain16", 7, 0, 13, 0);
    step(1, 1, 0, 1, "chain_mid_rst", 7, 0, 15, 0);
    step(1, 1, 0, 1, "chain_rst_hold", 7, 0, 15, 0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
